// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer: FSM state encodings and loss counter width.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_seq_state_t;

    localparam int unsigned LOSS_CNT_W = 8;

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; both stages reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer on the free-running reference clock.
// Optional lock-loss counter enabled by defining PLL_SEQ_LOSS_COUNTER_EN.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  sw_relock,
    output logic                  pll_rst,
    output logic                  sys_rst_out,
    output logic                  ready,
    output logic                  fault,
    output logic [2:0]            state_o,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

    pll_seq_state_t     state, state_nxt;
    logic [CNT_W-1:0]   timer, timer_nxt;
    logic [RETRY_W-1:0] retry, retry_nxt, retry_inc;
    logic               locked_s;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    always_comb begin
        state_nxt = state;
        timer_nxt = timer + 1'b1;
        retry_nxt = retry;
        retry_inc = retry + 1'b1;
        unique case (state)
            RESET_PLL: begin
                if (timer == CNT_W'(RST_CYCLES - 1)) begin
                    state_nxt = WAIT_LOCK;
                    timer_nxt = '0;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = STABLE;
                    timer_nxt = '0;
                end else if (timer == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    retry_nxt = retry_inc;
                    timer_nxt = '0;
                    state_nxt = (retry_inc == RETRY_W'(MAX_RETRY)) ? FAULT : RESET_PLL;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    timer_nxt = '0;
                end else if (timer == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_nxt = RUN;
                    timer_nxt = '0;
                    retry_nxt = '0;
                end
            end
            RUN: begin
                timer_nxt = '0;
                if (!locked_s) state_nxt = RESET_PLL;
            end
            FAULT: begin
                timer_nxt = '0;
            end
            default: begin
                state_nxt = RESET_PLL;
                timer_nxt = '0;
            end
        endcase
        // A relock request overrides whatever the state decided this cycle.
        if (sw_relock) begin
            state_nxt = RESET_PLL;
            timer_nxt = '0;
            retry_nxt = '0;
        end
    end

    // Outputs are registered from the next state so they move with the state register.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state       <= RESET_PLL;
            timer       <= '0;
            retry       <= '0;
            pll_rst     <= 1'b1;
            sys_rst_out <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            retry       <= retry_nxt;
            pll_rst     <= (state_nxt == RESET_PLL) || (state_nxt == FAULT);
            sys_rst_out <= (state_nxt != RUN);
            ready       <= (state_nxt == RUN);
            fault       <= (state_nxt == FAULT);
        end
    end

    assign state_o = state;

`ifdef PLL_SEQ_LOSS_COUNTER_EN
    logic                  loss_event;
    logic [LOSS_CNT_W-1:0] loss_cnt;

    // Counted even when a relock request coincides with the loss.
    assign loss_event = (state == RUN) && !locked_s;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            loss_cnt <= '0;
        end else if (loss_event && (loss_cnt != '1)) begin
            loss_cnt <= loss_cnt + 1'b1;
        end
    end

    assign lock_loss_cnt = loss_cnt;
`else
    assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters.
module tb_pll_lock_sequencer;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       sw_relock = 1'b0;
    logic       pll_rst, sys_rst_out, ready, fault;
    logic [2:0] state_o;
    logic [7:0] lock_loss_cnt;

    int checks = 0;
    int failures = 0;

    pll_lock_sequencer #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRY     (2),
        .CNT_W         (16)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .sw_relock     (sw_relock),
        .pll_rst       (pll_rst),
        .sys_rst_out   (sys_rst_out),
        .ready         (ready),
        .fault         (fault),
        .state_o       (state_o),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic        rst;
        logic        lock;
        logic        relock;
        int unsigned cyc;
        logic [2:0]  st;
        logic        prst;
        logic        srst;
        logic        rdy;
        logic        flt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic l, logic s, int unsigned c,
                                logic [2:0] st, logic p, logic y, logic d, logic f);
        vec_t v;
        v.rst = r; v.lock = l; v.relock = s; v.cyc = c;
        v.st = st; v.prst = p; v.srst = y; v.rdy = d; v.flt = f;
        return v;
    endfunction

    function automatic int exp_cnt(int n);
`ifdef PLL_SEQ_LOSS_COUNTER_EN
        return (n > 255) ? 255 : n;
`else
        return 0;
`endif
    endfunction

    task automatic step(int unsigned n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Packs {state, pll_rst, sys_rst_out, ready, fault}.
    task automatic check_outs(string name, logic [2:0] st, logic p, logic y, logic d, logic f);
        check(name, {25'd0, state_o, pll_rst, sys_rst_out, ready, fault},
                    {25'd0, st, p, y, d, f});
    endtask

    task automatic wait_ready(string name);
        for (int i = 0; i < 60; i++) begin
            if (ready) break;
            step(1);
        end
        check(name, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        // Scenario 1: lock 5 cycles after pll_rst falls; RUN 11 edges after lock rises.
        vq.push_back(mk(1, 0, 0, 2,  3'd0, 1, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 3,  3'd0, 1, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 1,  3'd1, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 5,  3'd1, 0, 1, 0, 0));
        vq.push_back(mk(0, 1, 0, 10, 3'd2, 0, 1, 0, 0));
        vq.push_back(mk(0, 1, 0, 1,  3'd3, 0, 0, 1, 0));
        vq.push_back(mk(0, 1, 0, 5,  3'd3, 0, 0, 1, 0));
        // Scenario 2: no lock -> two attempts then FAULT; relock clears timer and retry.
        vq.push_back(mk(1, 0, 0, 1,  3'd0, 1, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 3,  3'd0, 1, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 1,  3'd1, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 19, 3'd1, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 1,  3'd0, 1, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 3,  3'd0, 1, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 1,  3'd1, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 19, 3'd1, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 1,  3'd4, 1, 1, 0, 1));
        vq.push_back(mk(0, 0, 0, 10, 3'd4, 1, 1, 0, 1));
        vq.push_back(mk(0, 0, 1, 1,  3'd0, 1, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 3,  3'd0, 1, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 1,  3'd1, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 19, 3'd1, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 1,  3'd0, 1, 1, 0, 0));

        for (int i = 0; i < vq.size(); i++) begin
            rst = vq[i].rst;
            pll_locked = vq[i].lock;
            sw_relock = vq[i].relock;
            step(vq[i].cyc);
            check_outs($sformatf("vec%0d", i), vq[i].st, vq[i].prst, vq[i].srst,
                       vq[i].rdy, vq[i].flt);
            check($sformatf("vec%0d_cnt", i), {24'd0, lock_loss_cnt}, 32'd0);
        end

        // Scenario 3: one-cycle lock glitch in STABLE restarts qualification.
        rst = 1'b1; pll_locked = 1'b0; sw_relock = 1'b0;
        step(1);
        rst = 1'b0;
        step(4);
        check_outs("glitch_wait", 3'd1, 0, 1, 0, 0);
        pll_locked = 1'b1;
        step(3);
        check_outs("glitch_stable", 3'd2, 0, 1, 0, 0);
        step(4);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(2);
        check_outs("glitch_back", 3'd1, 0, 1, 0, 0);
        step(8);
        check_outs("glitch_not_yet", 3'd2, 0, 1, 0, 0);
        step(1);
        check_outs("glitch_run", 3'd3, 0, 0, 1, 0);

        // Scenario 5: relock coincident with lock loss in RUN counts the loss once.
        pll_locked = 1'b0;
        step(2);
        check_outs("coinc_pre", 3'd3, 0, 0, 1, 0);
        sw_relock = 1'b1;
        step(1);
        sw_relock = 1'b0;
        check_outs("coinc_reset", 3'd0, 1, 1, 0, 0);
        check("coinc_cnt", {24'd0, lock_loss_cnt}, exp_cnt(1));
        step(5);
        check_outs("coinc_wait", 3'd1, 0, 1, 0, 0);
        check("coinc_cnt_hold", {24'd0, lock_loss_cnt}, exp_cnt(1));
        pll_locked = 1'b1;
        wait_ready("coinc_relock");

        // Scenario 4: 300 lock losses in RUN; counter saturates.
        for (int k = 0; k < 300; k++) begin
            pll_locked = 1'b0;
            step(2);
            if (k < 3) check_outs($sformatf("loss%0d_pre", k), 3'd3, 0, 0, 1, 0);
            step(1);
            check_outs($sformatf("loss%0d", k), 3'd0, 1, 1, 0, 0);
            if (k == 0) check("loss_cnt_first", {24'd0, lock_loss_cnt}, exp_cnt(2));
            pll_locked = 1'b1;
            wait_ready($sformatf("loss%0d_rerun", k));
        end
        check("loss_cnt_sat", {24'd0, lock_loss_cnt}, exp_cnt(301));

        // Scenario 6: asynchronous rst mid-WAIT_LOCK.
        pll_locked = 1'b0;
        step(7);
        check_outs("arst_pre", 3'd1, 0, 1, 0, 0);
        check("arst_pre_cnt", {24'd0, lock_loss_cnt}, exp_cnt(302));
        #3;
        rst = 1'b1;
        #1;
        check_outs("arst_now", 3'd0, 1, 1, 0, 0);
        check("arst_cnt", {24'd0, lock_loss_cnt}, 32'd0);
        step(2);
        rst = 1'b0;
        step(2);
        check_outs("arst_release", 3'd0, 1, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
